ppu_bbus_master: RTL and testbench

//  CPU-side initiator for the PPU1/PPU2 B-Bus, replacing the hard-tied idle levels on

---
 rtl/ppu_bbus_master.sv | 187 ++++++++++++++++++
 tb/tb_ppu_bbus_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_bbus_master.sv
// rtl/ppu_bbus_master.sv - CPU-side B-Bus initiator for PPU1/PPU2 register access
//
// Purpose:
//   Runs one B-Bus register read or write per accepted command. It drives PA, PD,
//   the active-low strobes and the level-shifter directions, and each phase lasts a
//   programmable number of clock cycles. Read data comes back on a one-cycle response
//   pulse.
//
// Ports:
//   clock, reset             single clock; asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only while idle)
//   cmd_write/addr/wdata     command fields, latched on the accept edge
//   rsp_valid/rsp_rdata      read response pulse and held read data
//   busy                     high while a bus cycle is in progress
//   pa, pd_out, pd_oe, pd_in B-Bus address, data out, data drive enable, data in
//   pard_n, pawr_n           read and write strobes, active low
//   lvl_pa_dir, lvl_pd_dir   level-shifter directions, 1 = FPGA->PPU

module ppu_bbus_master #(
  parameter int unsigned TURN_CYCLES   = 1,
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [7:0] pa,
  output logic [7:0] pd_out,
  output logic       pd_oe,
  input  logic [7:0] pd_in,
  output logic       pard_n,
  output logic       pawr_n,
  output logic       lvl_pa_dir,
  output logic       lvl_pd_dir
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN_ON,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_TURN_OFF
  } state_t;

  // The phase counter is loaded with N-1 on entry and the phase ends when it reaches 0.
  localparam logic [7:0] TURN_LOAD   = 8'(TURN_CYCLES - 1);
  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       wr_q;
  logic       wr_nx;
  logic       accept;
  logic       phase_done;
  logic       strobe_nx;
  logic       drive_nx;
  logic       dir_nx;
  logic       sample_rd;

  // lvl_pa_dir doubles as an "out of reset" flag. Without it, cmd_ready would be high
  // while reset holds the state machine in IDLE.
  assign cmd_ready  = (state == S_IDLE) && lvl_pa_dir;
  assign busy       = (state != S_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign phase_done = (cnt == 8'd0);

  // The read data is captured on the edge that ends the last strobe cycle.
  assign sample_rd  = (state == S_STROBE) && phase_done && !wr_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = phase_done ? cnt : cnt - 8'd1;
    wr_nx    = wr_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          wr_nx = cmd_write;
          if (cmd_write) begin
            state_nx = S_TURN_ON;
            cnt_nx   = TURN_LOAD;
          end else begin
            state_nx = S_SETUP;
            cnt_nx   = SETUP_LOAD;
          end
        end
      end
      S_TURN_ON: begin
        if (phase_done) begin
          state_nx = S_SETUP;
          cnt_nx   = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (phase_done) begin
          state_nx = S_STROBE;
          cnt_nx   = STROBE_LOAD;
        end
      end
      S_STROBE: begin
        if (phase_done) begin
          state_nx = S_HOLD;
          cnt_nx   = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (phase_done) begin
          if (wr_q) begin
            state_nx = S_TURN_OFF;
            cnt_nx   = TURN_LOAD;
          end else begin
            state_nx = S_IDLE;
            cnt_nx   = 8'd0;
          end
        end
      end
      S_TURN_OFF: begin
        if (phase_done) begin
          state_nx = S_IDLE;
          cnt_nx   = 8'd0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Pin levels are decoded from the next state and registered. Each pin therefore
  // changes on the same edge that enters its phase, and no combinational glitch can
  // reach the PPU. PD is driven only inside the turn-on/turn-off bracket, so pd_oe
  // can never be high while the PD shifter points toward the FPGA.
  assign strobe_nx = (state_nx == S_STROBE);
  assign dir_nx    = wr_nx && (state_nx != S_IDLE);
  assign drive_nx  = wr_nx && ((state_nx == S_SETUP) || (state_nx == S_STROBE) ||
                               (state_nx == S_HOLD));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      wr_q       <= 1'b0;
      pard_n     <= 1'b1;
      pawr_n     <= 1'b1;
      pd_oe      <= 1'b0;
      lvl_pd_dir <= 1'b0;
      lvl_pa_dir <= 1'b0;
      pa         <= 8'd0;
      pd_out     <= 8'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      wr_q       <= wr_nx;
      lvl_pa_dir <= 1'b1;
      pard_n     <= !(strobe_nx && !wr_nx);
      pawr_n     <= !(strobe_nx && wr_nx);
      pd_oe      <= drive_nx;
      lvl_pd_dir <= dir_nx;
      if (accept) begin
        pa     <= cmd_addr;
        pd_out <= cmd_wdata;
      end
      // pd_in is not synchronised. The PPU has had the whole strobe window to settle
      // the bus by the time this edge samples it.
      rsp_valid <= sample_rd;
      if (sample_rd) begin
        rsp_rdata <= pd_in;
      end
    end
  end

endmodule

// File: tb/tb_ppu_bbus_master.sv
// tb/tb_ppu_bbus_master.sv - directed vector bench for ppu_bbus_master
module tb_ppu_bbus_master;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic [7:0] pd_in = 8'hAA;

  logic       cmd_valid_a, ready_a, rsp_valid_a, busy_a, pd_oe_a, pard_n_a, pawr_n_a;
  logic       lvl_pa_dir_a, lvl_pd_dir_a;
  logic [7:0] rsp_rdata_a, pa_a, pd_out_a;
  logic       cmd_valid_b, ready_b, rsp_valid_b, busy_b, pd_oe_b, pard_n_b, pawr_n_b;
  logic       lvl_pa_dir_b, lvl_pd_dir_b;
  logic [7:0] rsp_rdata_b, pa_b, pd_out_b;

  assign cmd_valid_a = cmd_valid & ~sel;
  assign cmd_valid_b = cmd_valid & sel;

  ppu_bbus_master u_dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid_a), .cmd_ready(ready_a),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .busy(busy_a), .pa(pa_a),
    .pd_out(pd_out_a), .pd_oe(pd_oe_a), .pd_in(pd_in), .pard_n(pard_n_a),
    .pawr_n(pawr_n_a), .lvl_pa_dir(lvl_pa_dir_a), .lvl_pd_dir(lvl_pd_dir_a)
  );

  ppu_bbus_master #(
    .TURN_CYCLES(1), .SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)
  ) u_dut_min (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_ready(ready_b),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b), .pa(pa_b),
    .pd_out(pd_out_b), .pd_oe(pd_oe_b), .pd_in(pd_in), .pard_n(pard_n_b),
    .pawr_n(pawr_n_b), .lvl_pa_dir(lvl_pa_dir_b), .lvl_pd_dir(lvl_pd_dir_b)
  );

  logic       o_ready, o_rsp_valid, o_busy, o_pd_oe, o_pard_n, o_pawr_n, o_lvl_pd_dir;
  logic [7:0] o_rsp_rdata, o_pa, o_pd_out;
  assign o_ready      = sel ? ready_b      : ready_a;
  assign o_rsp_valid  = sel ? rsp_valid_b  : rsp_valid_a;
  assign o_busy       = sel ? busy_b       : busy_a;
  assign o_pd_oe      = sel ? pd_oe_b      : pd_oe_a;
  assign o_pard_n     = sel ? pard_n_b     : pard_n_a;
  assign o_pawr_n     = sel ? pawr_n_b     : pawr_n_a;
  assign o_lvl_pd_dir = sel ? lvl_pd_dir_b : lvl_pd_dir_a;
  assign o_rsp_rdata  = sel ? rsp_rdata_b  : rsp_rdata_a;
  assign o_pa         = sel ? pa_b         : pa_a;
  assign o_pd_out     = sel ? pd_out_b     : pd_out_a;

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle indices count from the first cycle after the accept edge. -1 means "never".
  typedef struct {
    bit       sel;
    bit       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] pdv;
    logic [7:0] rdata;
    int       busy;
    int       stb_len;
    int       stb_first;
    int       dir_first;
    int       dir_last;
    int       oe_first;
    int       oe_last;
    int       rsp_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_ready(input string name);
    int waited = 0;
    while (!o_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk(name, o_ready, 1'b1);
  endtask

  task automatic run_cmd(input int idx, input vec_t v);
    int busy_cnt = 0, stb_cnt = 0, stb_first = -1, other_low = 0, viol = 0;
    int dir_first = -1, dir_last = -1, oe_first = -1, oe_last = -1;
    int rsp_cyc = -1, rsp_cnt = 0;
    logic [7:0] rdata = 8'h00;
    bit done = 0, ready_end = 0;
    bit obs_stb, obs_other;
    @(negedge clock);
    sel = v.sel;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    #1;
    wait_ready($sformatf("v%0d ready", idx));
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      obs_stb   = v.wr ? !o_pawr_n : !o_pard_n;
      obs_other = v.wr ? !o_pard_n : !o_pawr_n;
      if (!o_busy) begin
        done = 1;
        ready_end = o_ready;
      end else begin
        busy_cnt++;
        if (o_ready) viol++;
        if (o_pa !== v.addr) viol++;
        if (o_pd_oe && o_pd_out !== v.wdata) viol++;
        if (o_pd_oe && !o_lvl_pd_dir) viol++;
      end
      if (!o_pard_n && !o_pawr_n) viol++;
      if (obs_stb) begin
        stb_cnt++;
        if (stb_first < 0) stb_first = c;
      end
      if (obs_other) other_low++;
      if (o_lvl_pd_dir) begin
        if (dir_first < 0) dir_first = c;
        dir_last = c;
      end
      if (o_pd_oe) begin
        if (oe_first < 0) oe_first = c;
        oe_last = c;
      end
      if (o_rsp_valid) begin
        rsp_cnt++;
        rsp_cyc = c;
        rdata = o_rsp_rdata;
      end
      // Real data only during the last strobe cycle, so an early sample shows up.
      pd_in = (!o_pard_n && stb_cnt == v.stb_len) ? v.pdv : 8'hAA;
    end
    pd_in = 8'hAA;
    chk($sformatf("v%0d finished", idx), done, 1'b1);
    chk($sformatf("v%0d busy cycles", idx), busy_cnt, v.busy);
    chk($sformatf("v%0d strobe len", idx), stb_cnt, v.stb_len);
    chk($sformatf("v%0d strobe first", idx), stb_first, v.stb_first);
    chk($sformatf("v%0d other strobe", idx), other_low, 0);
    chk($sformatf("v%0d pd_dir first", idx), dir_first, v.dir_first);
    chk($sformatf("v%0d pd_dir last", idx), dir_last, v.dir_last);
    chk($sformatf("v%0d pd_oe first", idx), oe_first, v.oe_first);
    chk($sformatf("v%0d pd_oe last", idx), oe_last, v.oe_last);
    chk($sformatf("v%0d rsp cycle", idx), rsp_cyc, v.rsp_cyc);
    chk($sformatf("v%0d rsp count", idx), rsp_cnt, v.wr ? 0 : 1);
    chk($sformatf("v%0d violations", idx), viol, 0);
    chk($sformatf("v%0d ready at idle", idx), ready_end, 1'b1);
    if (!v.wr) chk($sformatf("v%0d rsp_rdata", idx), rdata, v.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int overlap, pawr_cnt, pard_cnt, rsp_cnt, rsp_cyc;
    logic [7:0]  rdata;
    logic [19:0] busy_vec;

    //        sel wr  addr   wdata  pdv    rdata  busy len 1st dirF dirL oeF oeL rsp
    vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 9, 4, 3,  0,  8,  1,  7, -1};
    vecs[1] = '{1'b0, 1'b0, 8'h3F, 8'h00, 8'h03, 8'h03, 7, 4, 2, -1, -1, -1, -1,  6};
    vecs[2] = '{1'b0, 1'b1, 8'h21, 8'h0F, 8'h00, 8'h00, 9, 4, 3,  0,  8,  1,  7, -1};
    vecs[3] = '{1'b0, 1'b0, 8'h3E, 8'h00, 8'hA5, 8'hA5, 7, 4, 2, -1, -1, -1, -1,  6};
    vecs[4] = '{1'b1, 1'b1, 8'h05, 8'h5A, 8'h00, 8'h00, 5, 1, 2,  0,  4,  1,  3, -1};
    vecs[5] = '{1'b1, 1'b0, 8'h34, 8'h00, 8'hC3, 8'hC3, 3, 1, 1, -1, -1, -1, -1,  2};

    // Reset held from time zero: every output at its reset level.
    #12;
    chk("reset outputs a", {pard_n_a, pawr_n_a, pd_oe_a, lvl_pd_dir_a, lvl_pa_dir_a, pa_a,
        pd_out_a, rsp_valid_a, rsp_rdata_a, busy_a, ready_a},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    chk("reset outputs b", {pard_n_b, pawr_n_b, pd_oe_b, lvl_pd_dir_b, lvl_pa_dir_b,
        busy_b, ready_b}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("pa_dir before edge", {lvl_pa_dir_a, ready_a}, 2'b00);
    @(negedge clock);
    chk("pa_dir after edge", {lvl_pa_dir_a, ready_a, lvl_pa_dir_b, ready_b}, 4'b1111);

    for (int i = 0; i < 6; i++) run_cmd(i, vecs[i]);

    // Held cmd_valid: write $21/$0F, then read $3E accepted after one idle cycle.
    @(negedge clock);
    sel = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h21; cmd_wdata = 8'h0F;
    #1;
    wait_ready("b2b ready");
    @(posedge clock);
    overlap = 0; pawr_cnt = 0; pard_cnt = 0; rsp_cnt = 0; rsp_cyc = -1; rdata = 8'h00;
    busy_vec = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      busy_vec[c] = busy_a;
      if (!pard_n_a && !pawr_n_a) overlap++;
      if (!pawr_n_a) pawr_cnt++;
      if (!pard_n_a) pard_cnt++;
      if (rsp_valid_a) begin
        rsp_cnt++;
        rsp_cyc = c;
        rdata = rsp_rdata_a;
      end
      if (c == 5) chk("rsp_rdata held", rsp_rdata_a, 8'hA5);
      if (c == 0) begin
        cmd_write = 1'b0; cmd_addr = 8'h3E; cmd_wdata = 8'h00;
      end
      if (c == 10) begin
        cmd_valid = 1'b0;
        chk("b2b pa", pa_a, 8'h3E);
      end
      pd_in = !pard_n_a ? 8'h5C : 8'hAA;
    end
    pd_in = 8'hAA;
    chk("b2b busy pattern", busy_vec, 20'b000_1111111_0_111111111);
    chk("b2b overlap", overlap, 0);
    chk("b2b pawr len", pawr_cnt, 4);
    chk("b2b pard len", pard_cnt, 4);
    chk("b2b rsp count", rsp_cnt, 1);
    chk("b2b rsp cycle", rsp_cyc, 16);
    chk("b2b rsp_rdata", rdata, 8'h5C);

    // Reset pulse during the write strobe, with no clock edge inside the pulse.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h21; cmd_wdata = 8'h0F;
    #1;
    wait_ready("rst ready");
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("rst in strobe", {pawr_n_a, pd_oe_a, lvl_pd_dir_a}, 3'b011);
    #1 reset = 1'b1;
    #1;
    chk("rst async outputs", {pard_n_a, pawr_n_a, pd_oe_a, lvl_pd_dir_a, lvl_pa_dir_a, pa_a,
        pd_out_a, rsp_valid_a, rsp_rdata_a, busy_a, ready_a},
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    #1 reset = 1'b0;
    rsp_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (rsp_valid_a || busy_a) rsp_cnt++;
    end
    chk("rst no rsp/busy", rsp_cnt, 0);
    run_cmd(10, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
